// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the execute stage.
// Optional forwarding (MEM/WB result forwarding plus the capture-time WB
// bypass) is compiled in when ID_EX_STAGE_FWD_EN is defined; without it the
// operands come only from the latched register-file values, and hazards must
// be resolved upstream by stalling.
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        d_valid,
   input  logic [31:0] d_pc,
   input  logic [31:0] d_rs_val,
   input  logic [31:0] d_rt_val,
   input  logic [31:0] d_imm32,
   input  logic [4:0]  d_rs_addr,
   input  logic [4:0]  d_rt_addr,
   input  logic [4:0]  d_wa,
   input  logic        d_we,
   input  logic        d_alusrc,
   input  logic [2:0]  d_alu_op,
   input  logic        stall,
   input  logic        flush,
   input  logic        m_we,
   input  logic [4:0]  m_wa,
   input  logic [31:0] m_val,
   input  logic        w_we,
   input  logic [4:0]  w_wa,
   input  logic [31:0] w_val,
   output logic        e_valid,
   output logic [31:0] e_pc,
   output logic [31:0] e_A,
   output logic [31:0] e_B,
   output logic [2:0]  e_op,
   output logic [31:0] e_store,
   output logic [4:0]  e_wa,
   output logic        e_we
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] rs_val_q;
   logic [31:0] rt_val_q;
   logic [31:0] imm_q;
   logic [4:0]  rs_addr_q;
   logic [4:0]  rt_addr_q;
   logic [4:0]  wa_q;
   logic        we_q;
   logic        alusrc_q;
   logic [2:0]  op_q;

   logic [31:0] rs_cap;
   logic [31:0] rt_cap;
   logic [31:0] rs_fwd;
   logic [31:0] rt_fwd;

`ifdef ID_EX_STAGE_FWD_EN
   // Forwarding source select for one latched register; MEM beats WB, r0 never forwards.
   function automatic logic [31:0] fwd_sel(input logic [4:0] r, input logic [31:0] v,
                                           input logic mwe, input logic [4:0] mwa,
                                           input logic [31:0] mval, input logic wwe,
                                           input logic [4:0] wwa, input logic [31:0] wval);
      logic [31:0] res;
      res = v;
      if (r != 5'd0) begin
         if (mwe && (mwa == r))      res = mval;
         else if (wwe && (wwa == r)) res = wval;
      end
      return res;
   endfunction

   // Capture-time WB bypass: the register file has not yet absorbed the WB write.
   always_comb begin
      rs_cap = d_rs_val;
      rt_cap = d_rt_val;
      if (w_we && (w_wa != 5'd0) && (w_wa == d_rs_addr)) rs_cap = w_val;
      if (w_we && (w_wa != 5'd0) && (w_wa == d_rt_addr)) rt_cap = w_val;
   end

   // Execute-side operand forwarding from the latched register numbers.
   always_comb begin
      rs_fwd = fwd_sel(rs_addr_q, rs_val_q, m_we, m_wa, m_val, w_we, w_wa, w_val);
      rt_fwd = fwd_sel(rt_addr_q, rt_val_q, m_we, m_wa, m_val, w_we, w_wa, w_val);
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{m_we, m_wa, m_val, w_we, w_wa, w_val, rs_addr_q, rt_addr_q};

   // Without forwarding the operands are the latched register-file values.
   always_comb begin
      rs_cap = d_rs_val;
      rt_cap = d_rt_val;
      rs_fwd = rs_val_q;
      rt_fwd = rt_val_q;
   end
`endif

   // Pipeline register: reset beats bubble beats capture.
   always_ff @(posedge clk) begin
      if (reset || stall || flush) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rs_val_q  <= '0;
         rt_val_q  <= '0;
         imm_q     <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         wa_q      <= '0;
         we_q      <= 1'b0;
         alusrc_q  <= 1'b0;
         op_q      <= '0;
      end else begin
         valid_q   <= d_valid;
         pc_q      <= d_pc;
         rs_val_q  <= rs_cap;
         rt_val_q  <= rt_cap;
         imm_q     <= d_imm32;
         rs_addr_q <= d_rs_addr;
         rt_addr_q <= d_rt_addr;
         wa_q      <= d_wa;
         we_q      <= d_valid & d_we;
         alusrc_q  <= d_alusrc;
         op_q      <= d_alu_op;
      end
   end

   // Output drive: operands after forwarding, control straight from the register.
   always_comb begin
      e_valid = valid_q;
      e_pc    = pc_q;
      e_A     = rs_fwd;
      e_store = rt_fwd;
      e_B     = alusrc_q ? imm_q : rt_fwd;
      e_op    = op_q;
      e_wa    = wa_q;
      e_we    = we_q;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes hand-computed expected
// outputs after each capture edge; a monitor pops and compares on negedge.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, d_valid, d_we, d_alusrc, stall, flush, m_we, w_we;
   logic [31:0] d_pc, d_rs_val, d_rt_val, d_imm32, m_val, w_val;
   logic [4:0]  d_rs_addr, d_rt_addr, d_wa, m_wa, w_wa;
   logic [2:0]  d_alu_op;
   logic        e_valid, e_we;
   logic [31:0] e_pc, e_A, e_B, e_store;
   logic [2:0]  e_op;
   logic [4:0]  e_wa;

   typedef struct {
      string       name;
      logic        valid;
      logic [31:0] pc, a, b, store;
      logic [2:0]  op;
      logic [4:0]  wa;
      logic        we;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_pc(d_pc),
      .d_rs_val(d_rs_val), .d_rt_val(d_rt_val), .d_imm32(d_imm32),
      .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr), .d_wa(d_wa),
      .d_we(d_we), .d_alusrc(d_alusrc), .d_alu_op(d_alu_op),
      .stall(stall), .flush(flush),
      .m_we(m_we), .m_wa(m_wa), .m_val(m_val),
      .w_we(w_we), .w_wa(w_wa), .w_val(w_val),
      .e_valid(e_valid), .e_pc(e_pc), .e_A(e_A), .e_B(e_B), .e_op(e_op),
      .e_store(e_store), .e_wa(e_wa), .e_we(e_we)
   );

   always #5 clk = ~clk;

   // Monitor: compare DUT outputs against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            tests++;
            if (e_valid !== x.valid || e_pc !== x.pc || e_A !== x.a || e_B !== x.b ||
                e_op !== x.op || e_store !== x.store || e_wa !== x.wa || e_we !== x.we) begin
               fails++;
               $display("FAIL %s: got v=%0b pc=%h A=%h B=%h op=%0d st=%h wa=%0d we=%0b; want v=%0b pc=%h A=%h B=%h op=%0d st=%h wa=%0d we=%0b",
                        x.name, e_valid, e_pc, e_A, e_B, e_op, e_store, e_wa, e_we,
                        x.valid, x.pc, x.a, x.b, x.op, x.store, x.wa, x.we);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic v, input logic [31:0] pc,
                             input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic [31:0] st, input logic [4:0] wa, input logic we);
      exp_t x;
      x.name = nm; x.valid = v; x.pc = pc; x.a = a; x.b = b;
      x.op = op; x.store = st; x.wa = wa; x.we = we;
      q.push_back(x);
      @(negedge clk);
      #1;
   endtask

   task automatic decode(input logic v, input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] rsa,
                         input logic [4:0] rta, input logic [4:0] wa, input logic we,
                         input logic src, input logic [2:0] op);
      d_valid = v; d_pc = pc; d_rs_val = rs; d_rt_val = rt; d_imm32 = imm;
      d_rs_addr = rsa; d_rt_addr = rta; d_wa = wa; d_we = we; d_alusrc = src; d_alu_op = op;
   endtask

   task automatic fwd_in(input logic mwe, input logic [4:0] mwa, input logic [31:0] mval,
                         input logic wwe, input logic [4:0] wwa, input logic [31:0] wval);
      m_we = mwe; m_wa = mwa; m_val = mval; w_we = wwe; w_wa = wwa; w_val = wval;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      fwd_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      // Reset wins over a valid decode and a capture.
      decode(1'b1, 32'h40, 32'h9, 32'h9, 32'h9, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 3'b001);
      cycle();
      expect_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 1'b0);
      reset = 1'b0;

      decode(1'b1, 32'h100, 32'd5, 32'd3, 32'h77, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 3'b001);
      cycle();
      expect_out("capture", 1'b1, 32'h100, 32'd5, 32'd3, 3'b001, 32'd3, 5'd3, 1'b1);

      decode(1'b1, 32'h104, 32'h10, 32'h7, 32'hFFFF_FFF0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 3'b000);
      cycle();
      expect_out("alusrc_imm", 1'b1, 32'h104, 32'h10, 32'hFFFF_FFF0, 3'b000, 32'h7, 5'd6, 1'b1);

      decode(1'b1, 32'h108, 32'h21, 32'h22, 32'h23, 5'd7, 5'd10, 5'd11, 1'b1, 1'b0, 3'b010);
      stall = 1'b1;
      cycle();
      expect_out("stall_bubble", 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 1'b0);
      stall = 1'b0;
      cycle();
      expect_out("after_stall", 1'b1, 32'h108, 32'h21, 32'h22, 3'b010, 32'h22, 5'd11, 1'b1);

      flush = 1'b1;
      cycle();
      expect_out("flush_bubble", 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 1'b0);
      stall = 1'b1;
      cycle();
      expect_out("stall_flush", 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 1'b0);
      stall = 1'b0; flush = 1'b0;

      decode(1'b0, 32'h200, 32'h11, 32'h22, 32'h33, 5'd12, 5'd13, 5'd5, 1'b1, 1'b0, 3'b010);
      cycle();
      expect_out("invalid_capture", 1'b0, 32'h200, 32'h11, 32'h22, 3'b010, 32'h22, 5'd5, 1'b0);

      decode(1'b1, 32'h300, 32'h44, 32'h55, 32'h66, 5'd14, 5'd15, 5'd16, 1'b1, 1'b1, 3'b001);
      cycle();
      expect_out("pre_reset", 1'b1, 32'h300, 32'h44, 32'h66, 3'b001, 32'h55, 5'd16, 1'b1);
      reset = 1'b1;
      cycle();
      expect_out("reset_mid", 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 1'b0);
      reset = 1'b0;
      decode(1'b1, 32'h304, 32'h1, 32'h2, 32'h3, 5'd17, 5'd18, 5'd19, 1'b0, 1'b0, 3'b000);
      cycle();
      expect_out("after_reset", 1'b1, 32'h304, 32'h1, 32'h2, 3'b000, 32'h2, 5'd19, 1'b0);

`ifdef ID_EX_STAGE_FWD_EN
      decode(1'b1, 32'h400, 32'h8, 32'h0, 32'h0, 5'd8, 5'd0, 5'd1, 1'b1, 1'b0, 3'b000);
      cycle();
      fwd_in(1'b1, 5'd8, 32'hAA, 1'b1, 5'd8, 32'hBB);
      expect_out("fwd_mem_prio", 1'b1, 32'h400, 32'hAA, 32'h0, 3'b000, 32'h0, 5'd1, 1'b1);
      fwd_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      cycle();
      fwd_in(1'b0, 5'd8, 32'hAA, 1'b1, 5'd8, 32'hBB);
      expect_out("fwd_wb", 1'b1, 32'h400, 32'hBB, 32'h0, 3'b000, 32'h0, 5'd1, 1'b1);

      fwd_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5A5A);
      decode(1'b1, 32'h404, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 3'b000);
      cycle();
      fwd_in(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
      expect_out("r0_guard", 1'b1, 32'h404, 32'h0, 32'h0, 3'b000, 32'h0, 5'd2, 1'b1);

      fwd_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234);
      decode(1'b1, 32'h408, 32'h0, 32'h1, 32'h0, 5'd0, 5'd9, 5'd3, 1'b1, 1'b0, 3'b000);
      cycle();
      fwd_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      expect_out("cap_bypass", 1'b1, 32'h408, 32'h0, 32'h1234, 3'b000, 32'h1234, 5'd3, 1'b1);
`else
      fwd_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hBB);
      decode(1'b1, 32'h400, 32'h55, 32'h66, 32'h0, 5'd8, 5'd9, 5'd1, 1'b1, 1'b0, 3'b000);
      cycle();
      fwd_in(1'b1, 5'd8, 32'hAA, 1'b1, 5'd9, 32'hBB);
      expect_out("no_fwd", 1'b1, 32'h400, 32'h55, 32'h66, 3'b000, 32'h66, 5'd1, 1'b1);
`endif

      for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
